// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants for the decode-stage register file.
package mips_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/register_file_if.sv
// Read/write port bundle between decode logic (master) and the register file (slave).
interface register_file_if;
    import mips_pkg::*;

    logic [REG_ADDR_W-1:0] Ard1;
    logic [REG_ADDR_W-1:0] Ard2;
    logic [REG_ADDR_W-1:0] Awr;
    logic                  WrEn;
    logic [DATA_W-1:0]     Din;
    logic [DATA_W-1:0]     Dout1;
    logic [DATA_W-1:0]     Dout2;

    modport master (output Ard1, Ard2, Awr, WrEn, Din, input Dout1, Dout2);
    modport slave  (input Ard1, Ard2, Awr, WrEn, Din, output Dout1, Dout2);
endinterface

// File: rtl/dec5to32.sv
// 5-to-32 one-hot address decoder driving the register write enables.
module dec5to32 (
    input  logic [4:0]  Adr,
    output logic [31:0] Out
);
    // one-hot decode of the address
    always_comb begin
        Out      = 32'd0;
        Out[Adr] = 1'b1;
    end
endmodule

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one clocked
// write port, r0 hard-wired to zero, optional write-through bypass.
module register_file #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic           Clk,
    input  logic           Rst_n,
    register_file_if.slave bus
);
    import mips_pkg::*;

    logic [31:0]       dec_out_s;
    logic [NREGS-1:0]  wr_en_s;
    logic [DATA_W-1:0] rd_array_s [NREGS];
    logic              byp1_s;
    logic              byp2_s;

    dec5to32 u_dec (
        .Adr (bus.Awr),
        .Out (dec_out_s)
    );

    // Bit 0 is forced low so r0 keeps its reset value of zero forever.
    assign wr_en_s = dec_out_s & {{(NREGS-1){bus.WrEn}}, 1'b0};

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        logic [DATA_W-1:0] q_r;

        // storage element with per-register enable
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                q_r <= '0;
            end else if (wr_en_s[i]) begin
                q_r <= bus.Din;
            end else begin
                q_r <= q_r;
            end
        end

        assign rd_array_s[i] = q_r;
    end

    assign byp1_s = (BYPASS != 0) && bus.WrEn && (bus.Awr != REG_ZERO) && (bus.Ard1 == bus.Awr);
    assign byp2_s = (BYPASS != 0) && bus.WrEn && (bus.Awr != REG_ZERO) && (bus.Ard2 == bus.Awr);

    // read muxes with independent write-through per port
    always_comb begin
        bus.Dout1 = rd_array_s[bus.Ard1];
        bus.Dout2 = rd_array_s[bus.Ard2];
        if (byp1_s) begin
            bus.Dout1 = bus.Din;
        end else begin
            bus.Dout1 = rd_array_s[bus.Ard1];
        end
        if (byp2_s) begin
            bus.Dout2 = bus.Din;
        end else begin
            bus.Dout2 = rd_array_s[bus.Ard2];
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: a bypassing and a non-bypassing instance driven in lockstep.
module tb_register_file;
    import mips_pkg::*;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;

    register_file_if bus_b ();
    register_file_if bus_n ();

    register_file #(.DATA_W(32), .NREGS(32), .BYPASS(1)) dut_b (
        .Clk (Clk), .Rst_n (Rst_n), .bus (bus_b.slave)
    );
    register_file #(.DATA_W(32), .NREGS(32), .BYPASS(0)) dut_n (
        .Clk (Clk), .Rst_n (Rst_n), .bus (bus_n.slave)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e1n;
        logic [31:0] e2n;
    } sb_t;

    typedef struct {
        logic [4:0]  ard1;
        logic [4:0]  ard2;
        logic [4:0]  awr;
        logic        wren;
        logic [31:0] din;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e1n;
        logic [31:0] e2n;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[15];
    int   checks = 0;
    int   errors = 0;

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] aw,
                         input logic we, input logic [31:0] d);
        bus_b.Ard1 = a1; bus_b.Ard2 = a2; bus_b.Awr = aw; bus_b.WrEn = we; bus_b.Din = d;
        bus_n.Ard1 = a1; bus_n.Ard2 = a2; bus_n.Awr = aw; bus_n.WrEn = we; bus_n.Din = d;
    endtask

    task automatic push(input string nm, input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] e1n, input logic [31:0] e2n);
        sb_t s;
        s.name = nm; s.e1 = e1; s.e2 = e2; s.e1n = e1n; s.e2n = e2n;
        sbq.push_back(s);
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // pop every pending expectation and compare against the live outputs
    task automatic sb_check();
        sb_t s;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            cmp({s.name, "/byp.d1"}, bus_b.Dout1, s.e1);
            cmp({s.name, "/byp.d2"}, bus_b.Dout2, s.e2);
            cmp({s.name, "/nob.d1"}, bus_n.Dout1, s.e1n);
            cmp({s.name, "/nob.d2"}, bus_n.Dout2, s.e2n);
        end
    endtask

    initial begin
        vecs[0]  = '{5'd0,  5'd0,  5'd0,  1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{5'd0,  5'd0,  5'd0,  1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[2]  = '{5'd7,  5'd7,  5'd7,  1'b1, 32'h11, 32'h11, 32'h11, 32'h1000_0007, 32'h1000_0007};
        vecs[3]  = '{5'd7,  5'd7,  5'd7,  1'b1, 32'h22, 32'h22, 32'h22, 32'h11, 32'h11};
        vecs[4]  = '{5'd7,  5'd7,  5'd0,  1'b0, 32'h0, 32'h22, 32'h22, 32'h22, 32'h22};
        vecs[5]  = '{5'd12, 5'd12, 5'd12, 1'b0, 32'hA5A5_A5A5, 32'h1000_000C, 32'h1000_000C, 32'h1000_000C, 32'h1000_000C};
        vecs[6]  = '{5'd12, 5'd11, 5'd0,  1'b0, 32'h0, 32'h1000_000C, 32'h1000_000B, 32'h1000_000C, 32'h1000_000B};
        vecs[7]  = '{5'd12, 5'd12, 5'd12, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h1000_000C, 32'h1000_000C};
        vecs[8]  = '{5'd11, 5'd13, 5'd0,  1'b0, 32'h0, 32'h1000_000B, 32'h1000_000D, 32'h1000_000B, 32'h1000_000D};
        vecs[9]  = '{5'd12, 5'd0,  5'd0,  1'b0, 32'h0, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, 32'h0};
        vecs[10] = '{5'd20, 5'd21, 5'd20, 1'b1, 32'h77, 32'h77, 32'h1000_0015, 32'h1000_0014, 32'h1000_0015};
        vecs[11] = '{5'd20, 5'd21, 5'd0,  1'b0, 32'h0, 32'h77, 32'h1000_0015, 32'h77, 32'h1000_0015};
        vecs[12] = '{5'd9,  5'd0,  5'd9,  1'b1, 32'h91, 32'h91, 32'h0, 32'h1000_0009, 32'h0};
        vecs[13] = '{5'd9,  5'd0,  5'd9,  1'b1, 32'h92, 32'h92, 32'h0, 32'h91, 32'h0};
        vecs[14] = '{5'd9,  5'd9,  5'd0,  1'b0, 32'h0, 32'h92, 32'h92, 32'h92, 32'h92};

        drive(5'd0, 5'd31, 5'd0, 1'b0, 32'h0);
        #2;
        push("por", 32'h0, 32'h0, 32'h0, 32'h0);
        sb_check();
        @(negedge Clk);
        Rst_n = 1'b1;

        // asynchronous reset clears a live register before any clock edge
        @(negedge Clk);
        drive(5'd5, 5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF);
        @(negedge Clk);
        drive(5'd5, 5'd5, 5'd0, 1'b0, 32'h0);
        #1;
        push("r5_written", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        sb_check();
        #1 Rst_n = 1'b0;
        #1;
        push("async_rst", 32'h0, 32'h0, 32'h0, 32'h0);
        sb_check();
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(5'(i), 5'(31 - i), 5'd0, 1'b0, 32'h0);
            #1;
            push("post_rst", 32'h0, 32'h0, 32'h0, 32'h0);
            sb_check();
        end

        for (int i = 1; i < 32; i++) begin
            @(negedge Clk);
            drive(5'd0, 5'd0, 5'(i), 1'b1, 32'h1000_0000 + 32'(i));
        end
        @(negedge Clk);
        for (int i = 1; i < 32; i++) begin
            drive(5'(i), 5'(32 - i), 5'd0, 1'b0, 32'h0);
            #1;
            push("sweep", 32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(32 - i),
                 32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(32 - i));
            sb_check();
        end

        for (int v = 0; v < 15; v++) begin
            @(negedge Clk);
            drive(vecs[v].ard1, vecs[v].ard2, vecs[v].awr, vecs[v].wren, vecs[v].din);
            push($sformatf("vec%0d", v), vecs[v].e1, vecs[v].e2, vecs[v].e1n, vecs[v].e2n);
            #1;
            sb_check();
        end

        // reset asserted inside a write cycle must win over the write
        @(negedge Clk);
        drive(5'd3, 5'd12, 5'd3, 1'b1, 32'h55);
        #2 Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        drive(5'd3, 5'd12, 5'd0, 1'b0, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        push("rst_vs_write", 32'h0, 32'h0, 32'h0, 32'h0);
        sb_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
